// File: rtl/vfp_cfg_sequencer_if.sv
// AXI4-Lite bus bundle between the config sequencer (master) and the vfp register slave.
interface vfp_cfg_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid, awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid, wready;
    logic [1:0]              bresp;
    logic                    bvalid, bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid, arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid, rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/vfp_cfg_sequencer.sv
// Walks an (addr, data) table into the vfp config slave over AXI4-Lite, optionally
// reading each entry back, and reports done or the first failing entry.
module vfp_cfg_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 6,
    parameter bit VERIFY     = 1'b1,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  start,
    input  logic [IDX_WIDTH:0]    cfg_count,
    output logic [IDX_WIDTH-1:0]  tbl_idx,
    input  logic [ADDR_WIDTH-1:0] tbl_addr,
    input  logic [DATA_WIDTH-1:0] tbl_data,
    vfp_cfg_sequencer_if.master   m_axi,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [IDX_WIDTH-1:0]  err_idx
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, BRESP, READ, RDATA, NEXT, FINISH} state_t;

    typedef struct packed {
        logic [TMR_W-1:0]      tmr;
        logic [IDX_WIDTH:0]    count;
        logic [IDX_WIDTH-1:0]  idx;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  awvalid, wvalid, bready, arvalid, rready;
        logic                  busy, done, error;
        logic [1:0]            err_code;
        logic [IDX_WIDTH-1:0]  err_idx;
    } regs_t;

    state_t state, state_nxt;
    regs_t  r, rn;
    logic   aw_ok, w_ok, tmo, fail;
    logic [1:0] fail_code;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
            r     <= '0;
        end else begin
            state <= state_nxt;
            r     <= rn;
        end
    end

    always_comb begin
        state_nxt = state;
        rn        = r;
        fail      = 1'b0;
        fail_code = 2'd0;
        aw_ok     = !r.awvalid || m_axi.awready;
        w_ok      = !r.wvalid  || m_axi.wready;
        tmo       = (r.tmr == TMR_W'(TIMEOUT - 1));
        case (state)
            IDLE: if (start) begin
                rn.done     = 1'b0;
                rn.error    = 1'b0;
                rn.err_code = 2'd0;
                rn.err_idx  = '0;
                rn.count    = cfg_count;
                rn.idx      = '0;
                rn.busy     = 1'b1;
                state_nxt   = (cfg_count == '0) ? FINISH : LOAD;
            end
            // Valids are raised here so they are already high in the first WRITE cycle.
            LOAD: begin
                rn.addr    = tbl_addr;
                rn.data    = tbl_data;
                rn.awvalid = 1'b1;
                rn.wvalid  = 1'b1;
                state_nxt  = WRITE;
            end
            WRITE: begin
                rn.awvalid = r.awvalid && !m_axi.awready;
                rn.wvalid  = r.wvalid  && !m_axi.wready;
                if (aw_ok && w_ok) begin
                    rn.bready = 1'b1;
                    state_nxt = BRESP;
                end else if (tmo) begin
                    fail = 1'b1; fail_code = 2'd3;
                end
            end
            BRESP: if (m_axi.bvalid) begin
                rn.bready = 1'b0;
                if (m_axi.bresp != 2'b00) begin
                    fail = 1'b1; fail_code = 2'd1;
                end else if (VERIFY) begin
                    rn.arvalid = 1'b1;
                    state_nxt  = READ;
                end else begin
                    state_nxt  = NEXT;
                end
            end else if (tmo) begin
                fail = 1'b1; fail_code = 2'd3;
            end
            READ: if (m_axi.arready) begin
                rn.arvalid = 1'b0;
                rn.rready  = 1'b1;
                state_nxt  = RDATA;
            end else if (tmo) begin
                fail = 1'b1; fail_code = 2'd3;
            end
            RDATA: if (m_axi.rvalid) begin
                rn.rready = 1'b0;
                if (m_axi.rresp != 2'b00) begin
                    fail = 1'b1; fail_code = 2'd1;
                end else if (m_axi.rdata != r.data) begin
                    fail = 1'b1; fail_code = 2'd2;
                end else begin
                    state_nxt = NEXT;
                end
            end else if (tmo) begin
                fail = 1'b1; fail_code = 2'd3;
            end
            NEXT: if ({1'b0, r.idx} == r.count - (IDX_WIDTH+1)'(1)) begin
                state_nxt = FINISH;
            end else begin
                rn.idx    = r.idx + IDX_WIDTH'(1);
                state_nxt = LOAD;
            end
            FINISH: begin
                rn.done   = 1'b1;
                rn.busy   = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // First failure aborts the walk with every handshake signal released.
        if (fail) begin
            rn.awvalid  = 1'b0;
            rn.wvalid   = 1'b0;
            rn.bready   = 1'b0;
            rn.arvalid  = 1'b0;
            rn.rready   = 1'b0;
            rn.busy     = 1'b0;
            rn.error    = 1'b1;
            rn.err_code = fail_code;
            rn.err_idx  = r.idx;
            state_nxt   = IDLE;
        end
        rn.tmr = (state_nxt != state) ? '0 : r.tmr + TMR_W'(1);
    end

    assign m_axi.awaddr  = r.addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = r.awvalid;
    assign m_axi.wdata   = r.data;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = r.wvalid;
    assign m_axi.bready  = r.bready;
    assign m_axi.araddr  = r.addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = r.arvalid;
    assign m_axi.rready  = r.rready;

    assign tbl_idx  = r.idx;
    assign busy     = r.busy;
    assign done     = r.done;
    assign error    = r.error;
    assign err_code = r.err_code;
    assign err_idx  = r.err_idx;
endmodule

// File: tb/tb_vfp_cfg_sequencer.sv
// Directed bench: register-bank AXI-Lite slave with injectable stalls and faults.
module tb_vfp_cfg_sequencer;
    logic       ACLK, ARESETN, start;
    logic [6:0] cfg_count;
    logic [5:0] tbl_idx;
    logic [7:0] tbl_addr;
    logic [31:0] tbl_data;
    logic       busy, done, error;
    logic [1:0] err_code;
    logic [5:0] err_idx;

    int checks = 0, errors = 0;

    // slave knobs
    int          aw_delay = 0;
    bit          corrupt_en = 0, bresp_err_en = 0, ar_never = 0;
    logic [7:0]  corrupt_addr = 8'h08, bresp_err_addr = 8'h04;
    logic [31:0] data_key = 32'h0;

    // slave state and monitors
    logic [31:0] mem [0:63];
    logic [7:0]  aw_addr_q, ar_addr_q;
    logic [31:0] w_data_q;
    logic [1:0]  b_code;
    bit          aw_have, w_have, b_pend, r_pend;
    int          aw_wait;
    int          n_aw = 0, n_w = 0, n_ar = 0, n_ar_0c = 0;
    int          valid_cyc = 0, w_first = 0, ar_cyc = 0, both_cyc = 0;

    vfp_cfg_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) m();

    vfp_cfg_sequencer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .IDX_WIDTH(6), .VERIFY(1'b1), .TIMEOUT(15)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_count(cfg_count),
        .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .m_axi(m),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .err_idx(err_idx)
    );

    // table entry i: address 4*i, data (i+1) ^ data_key
    assign tbl_addr = {tbl_idx, 2'b00};
    assign tbl_data = (32'(tbl_idx) + 32'd1) ^ data_key;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [7:0]  wr_a;
    logic [31:0] wr_d;
    assign aw_hs = m.awvalid && m.awready;
    assign w_hs  = m.wvalid  && m.wready;
    assign b_hs  = m.bvalid  && m.bready;
    assign ar_hs = m.arvalid && m.arready;
    assign r_hs  = m.rvalid  && m.rready;
    assign wr_a  = aw_have ? aw_addr_q : m.awaddr;
    assign wr_d  = w_have  ? w_data_q  : m.wdata;

    initial begin ACLK = 1'b0; forever #5 ACLK = ~ACLK; end

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_have <= 0; w_have <= 0; b_pend <= 0; r_pend <= 0; aw_wait <= 0;
            aw_addr_q <= '0; ar_addr_q <= '0; w_data_q <= '0; b_code <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            if (aw_hs) begin aw_addr_q <= m.awaddr; aw_wait <= 0; n_aw <= n_aw + 1; end
            else if (m.awvalid) aw_wait <= aw_wait + 1;
            if (w_hs) begin w_data_q <= m.wdata; n_w <= n_w + 1; end
            if ((aw_hs || aw_have) && (w_hs || w_have)) begin
                mem[wr_a[7:2]] <= wr_d;
                b_pend  <= 1;
                b_code  <= (bresp_err_en && wr_a == bresp_err_addr) ? 2'b10 : 2'b00;
                aw_have <= 0; w_have <= 0;
            end else begin
                if (aw_hs) aw_have <= 1;
                if (w_hs)  w_have  <= 1;
            end
            if (b_hs) b_pend <= 0;
            if (ar_hs) begin
                ar_addr_q <= m.araddr; r_pend <= 1; n_ar <= n_ar + 1;
                if (m.araddr == 8'h0C) n_ar_0c <= n_ar_0c + 1;
            end
            if (r_hs) r_pend <= 0;
            if (m.awvalid || m.wvalid || m.arvalid) valid_cyc <= valid_cyc + 1;
            if (m.awvalid && !m.wvalid) w_first <= w_first + 1;
            if (m.arvalid) ar_cyc <= ar_cyc + 1;
            if (done && error) both_cyc <= both_cyc + 1;
        end
    end

    // slave responses change on the falling edge, away from the DUT's sampling edge
    always @(negedge ACLK) begin
        m.awready = m.awvalid && !aw_have && (aw_wait >= aw_delay);
        m.wready  = m.wvalid && !w_have;
        m.bvalid  = b_pend;
        m.bresp   = b_code;
        m.arready = m.arvalid && !ar_never;
        m.rvalid  = r_pend;
        m.rresp   = 2'b00;
        m.rdata   = (corrupt_en && ar_addr_q == corrupt_addr) ? 32'hFF : mem[ar_addr_q[7:2]];
    end

    task automatic run_seq(input logic [6:0] cnt, output int cyc);
        @(negedge ACLK); start = 1'b1; cfg_count = cnt;
        @(negedge ACLK); start = 1'b0;
        cyc = 0;
        while (busy && cyc < 300) begin cyc++; @(negedge ACLK); end
        checks++;
        if (busy) begin errors++; $display("FAIL seq_bound: busy still %0b after %0d cycles", busy, cyc); end
    endtask

    task automatic test_reset;
        ARESETN = 1'b0; start = 1'b0; cfg_count = '0;
        repeat (3) @(negedge ACLK);
        checks++; if ({m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready} !== 5'b0) begin errors++; $display("FAIL rst_valids: got %b want 00000", {m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready}); end
        checks++; if ({busy, done, error, err_code, err_idx, tbl_idx} !== 17'b0) begin errors++; $display("FAIL rst_status: got %h want 0", {busy, done, error, err_code, err_idx, tbl_idx}); end
        checks++; if ({m.awaddr, m.araddr, m.wdata} !== 48'b0) begin errors++; $display("FAIL rst_bus: got %h want 0", {m.awaddr, m.araddr, m.wdata}); end
        ARESETN = 1'b1;
        repeat (4) @(negedge ACLK);
        checks++; if (valid_cyc !== 0) begin errors++; $display("FAIL rst_idle_bus: got %0d valid cycles want 0", valid_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic;
        int cyc, aw0, w0, ar0, wf0;
        aw0 = n_aw; w0 = n_w; ar0 = n_ar; wf0 = w_first;
        run_seq(7'd4, cyc);
        checks++; if (cyc !== 25) begin errors++; $display("FAIL basic_busy_len: got %0d want 25", cyc); end
        checks++; if ({done, error, err_code} !== 4'b1000) begin errors++; $display("FAIL basic_status: got done=%b error=%b code=%0d want 1 0 0", done, error, err_code); end
        checks++; if ({mem[0], mem[1], mem[2], mem[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin errors++; $display("FAIL basic_mem: got %h %h %h %h want 1 2 3 4", mem[0], mem[1], mem[2], mem[3]); end
        checks++; if ({n_aw - aw0, n_w - w0, n_ar - ar0} !== {32'd4, 32'd4, 32'd4}) begin errors++; $display("FAIL basic_counts: got aw=%0d w=%0d ar=%0d want 4 4 4", n_aw - aw0, n_w - w0, n_ar - ar0); end
        checks++; if (w_first - wf0 !== 0) begin errors++; $display("FAIL basic_aw_w_together: got %0d split cycles want 0", w_first - wf0); end
        checks++; if (tbl_idx !== 6'd3) begin errors++; $display("FAIL basic_idx: got %0d want 3", tbl_idx); end
    endtask

    task automatic test_aw_delay;
        int cyc, aw0, w0, wf0;
        aw_delay = 3; data_key = 32'h100;
        aw0 = n_aw; w0 = n_w; wf0 = w_first;
        run_seq(7'd4, cyc);
        checks++; if (cyc !== 37) begin errors++; $display("FAIL awdly_busy_len: got %0d want 37", cyc); end
        checks++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL awdly_status: got done=%b error=%b want 1 0", done, error); end
        checks++; if ({n_aw - aw0, n_w - w0} !== {32'd4, 32'd4}) begin errors++; $display("FAIL awdly_counts: got aw=%0d w=%0d want 4 4", n_aw - aw0, n_w - w0); end
        checks++; if (w_first - wf0 !== 12) begin errors++; $display("FAIL awdly_w_first: got %0d want 12", w_first - wf0); end
        checks++; if ({mem[0], mem[3]} !== {32'h101, 32'h104}) begin errors++; $display("FAIL awdly_mem: got %h %h want 101 104", mem[0], mem[3]); end
        aw_delay = 0;
    endtask

    task automatic test_verify_mismatch;
        int cyc, aw0, c0;
        data_key = 32'h200; corrupt_en = 1;
        aw0 = n_aw; c0 = n_ar_0c;
        run_seq(7'd4, cyc);
        checks++; if ({done, error, err_code, err_idx} !== {1'b0, 1'b1, 2'd2, 6'd2}) begin errors++; $display("FAIL vfy_status: got done=%b error=%b code=%0d idx=%0d want 0 1 2 2", done, error, err_code, err_idx); end
        checks++; if (cyc !== 17) begin errors++; $display("FAIL vfy_busy_len: got %0d want 17", cyc); end
        checks++; if ({n_aw - aw0, n_ar_0c - c0} !== {32'd3, 32'd0}) begin errors++; $display("FAIL vfy_stop: got aw=%0d ar0c=%0d want 3 0", n_aw - aw0, n_ar_0c - c0); end
        corrupt_en = 0;
    endtask

    task automatic test_bresp_err;
        int cyc, ar0;
        data_key = 32'h0; bresp_err_en = 1;
        ar0 = n_ar;
        run_seq(7'd4, cyc);
        checks++; if ({done, error, err_code, err_idx} !== {1'b0, 1'b1, 2'd1, 6'd1}) begin errors++; $display("FAIL bresp_status: got done=%b error=%b code=%0d idx=%0d want 0 1 1 1", done, error, err_code, err_idx); end
        checks++; if (cyc !== 9 || n_ar - ar0 !== 1) begin errors++; $display("FAIL bresp_stop: got len=%0d ar=%0d want 9 1", cyc, n_ar - ar0); end
        bresp_err_en = 0; data_key = 32'h300;
        run_seq(7'd4, cyc);
        checks++; if ({done, error, err_code, err_idx} !== {1'b1, 1'b0, 2'd0, 6'd0}) begin errors++; $display("FAIL bresp_recover: got done=%b error=%b code=%0d idx=%0d want 1 0 0 0", done, error, err_code, err_idx); end
        checks++; if (mem[3] !== 32'h304) begin errors++; $display("FAIL bresp_recover_mem: got %h want 304", mem[3]); end
    endtask

    task automatic test_timeout;
        int cyc, a0;
        data_key = 32'h0; ar_never = 1;
        a0 = ar_cyc;
        run_seq(7'd4, cyc);
        checks++; if ({done, error, err_code, err_idx} !== {1'b0, 1'b1, 2'd3, 6'd0}) begin errors++; $display("FAIL tmo_status: got done=%b error=%b code=%0d idx=%0d want 0 1 3 0", done, error, err_code, err_idx); end
        checks++; if (ar_cyc - a0 !== 15 || cyc !== 18) begin errors++; $display("FAIL tmo_len: got arvalid=%0d busy=%0d want 15 18", ar_cyc - a0, cyc); end
        checks++; if (m.arvalid !== 1'b0) begin errors++; $display("FAIL tmo_arvalid: got %b want 0", m.arvalid); end
        ar_never = 0;
    endtask

    task automatic test_zero_count;
        int cyc, v0;
        v0 = valid_cyc;
        run_seq(7'd0, cyc);
        checks++; if (cyc !== 1 || {done, error} !== 2'b10) begin errors++; $display("FAIL zero_status: got len=%0d done=%b error=%b want 1 1 0", cyc, done, error); end
        checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL zero_bus: got %0d valid cycles want 0", valid_cyc - v0); end
    endtask

    task automatic test_reset_mid_write;
        int n, v0;
        aw_delay = 10;
        @(negedge ACLK); start = 1'b1; cfg_count = 7'd4;
        @(negedge ACLK); start = 1'b0;
        n = 0;
        while (!m.awvalid && n < 20) begin n++; @(negedge ACLK); end
        checks++; if (m.awvalid !== 1'b1) begin errors++; $display("FAIL midrst_enter_write: got awvalid %b want 1", m.awvalid); end
        repeat (2) @(negedge ACLK);
        #2 ARESETN = 1'b0;
        #1;
        checks++; if ({m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready, busy} !== 6'b0) begin errors++; $display("FAIL midrst_valids: got %b want 000000", {m.awvalid, m.wvalid, m.bready, m.arvalid, m.rready, busy}); end
        aw_delay = 0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        v0 = valid_cyc;
        repeat (5) @(negedge ACLK);
        checks++; if (valid_cyc - v0 !== 0 || {busy, done, tbl_idx} !== 8'b0) begin errors++; $display("FAIL midrst_idle: got valid=%0d busy=%b done=%b idx=%0d want 0 0 0 0", valid_cyc - v0, busy, done, tbl_idx); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_aw_delay;
        test_verify_mismatch;
        test_bresp_err;
        test_timeout;
        test_zero_count;
        test_reset_mid_write;
        checks++; if (both_cyc !== 0) begin errors++; $display("FAIL done_error_overlap: got %0d cycles want 0", both_cyc); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
